dram_access_unit: RTL and testbench
===================================

Name: dram_access_unit

Overview:
- Initiator side of the single-port data RAM interface: accepts load/store requests from the pipeline MEM stage over a valid/ready handshake.
- Drives the RAM's word-indexed load/store strobes, one access at a time.
- The RAM has no byte enables, so byte and halfword stores use read-modify-write. Loads are lane-extracted and sign- or zero-extended.
- Returns one response per request, including misalignment errors.

Parameters:
- XLEN, 32, data/address width.
- LINES, 1024, RAM depth in words; IDX_W = $clog2(LINES).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  XLEN  byte address
- req_store  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- req_unsigned  in  1  zero-extend load result
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  XLEN  formatted load data (0 for stores/errors)
- rsp_err  out  1  misaligned access, no RAM access performed
- mem_addr  out  XLEN  word index to RAM, {0, req_addr[IDX_W+1:2]}
- mem_load  out  1  RAM read strobe; data valid on mem_rdata next cycle
- mem_store  out  1  RAM write strobe
- mem_wdata  out  XLEN  RAM write data
- mem_rdata  in  XLEN  RAM read data (1-cycle latency, holds until next load)

Behaviour:
- Reset values: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0. mem_load and mem_store are 0 in any cycle with rst=1, even mid-operation.
- Request capture: all req_* fields are registered on acceptance.
- Address mapping: mem_addr comes from the latched address. Bits above IDX_W+1 are ignored, so accesses wrap modulo LINES words.
- Lane order is little-endian: byte lane = addr[1:0], half lane = addr[1].
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- FSM states: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR, RESP.
- IDLE:
  - req_ready=1; no other state asserts req_ready.
  - On accept: misaligned -> RESP with err=1; load -> LD_RD; word store -> ST_WR; byte/half store -> RMW_RD.
- LD_RD: mem_load=1 -> LD_CAP.
- LD_CAP: extract lane from mem_rdata. Sign-extend bit 7 (byte) or bit 15 (half) unless req_unsigned. Register into rsp_rdata -> RESP.
- ST_WR: mem_store=1, mem_wdata=req_wdata -> RESP.
- RMW_RD: mem_load=1 -> RMW_MRG.
- RMW_MRG: merge register = mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0] -> RMW_WR.
- RMW_WR: mem_store=1, mem_wdata=merge register -> RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_ready -> IDLE. A new request is accepted no earlier than the cycle after the handshake; no request/response overlap.
  - rsp_rdata=0 for stores and errors.
- Latency from accept cycle T to first rsp_valid: misaligned T+1, word store T+2, load T+3, sub-word store T+4.
- mem_load and mem_store are never both 1 in the same cycle.
- Reset mid-operation: the FSM returns to IDLE and the partial operation is dropped without a write. An RMW interrupted before RMW_WR leaves the RAM unchanged. A response pending in RESP is discarded.
- req_* inputs are don't-care outside IDLE.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10 -> mem_addr=4 on both accesses; rsp_rdata=0xDEADBEEF at T+3; rsp_err=0.
- Byte RMW: word 0x11223344 at 0x20, store byte 0xAA at 0x22 -> one mem_load then one mem_store with mem_wdata=0x11AA3344; response at T+4.
- Sign/zero extension on word 0x8000F0FF:
  - lb at addr 0 -> 0xFFFFFFFF; lbu at addr 0 -> 0x000000FF.
  - lh at addr 2 -> 0xFFFF8000; lhu at addr 2 -> 0x00008000.
- Misaligned: lw at 0x6 and lh at 0x3 -> rsp_err=1, rsp_rdata=0, response at T+1, mem_load/mem_store never asserted.
- Backpressure and wrap:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0.
  - Address 4*LINES+8 (with LINES=1024) -> mem_addr=2.
- Reset in RMW_MRG: word 0x55555555 at addr 0, issue sb 0x00 at addr 0, assert rst one cycle in RMW_MRG -> no mem_store; later lw at addr 0 returns 0x55555555; rsp_valid=0 after reset.

Source files
------------

// File: rtl/dram_access_unit_if.sv
// Request/response bundle between the MEM stage (master) and the data RAM access unit (slave).
// Valid/ready rule: a transfer happens on a rising clk edge where valid and ready are both 1;
// the sender keeps valid and its payload stable until that edge, and ready never waits on valid.
interface dram_access_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_store;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr, req_store, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_store, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dram_access_unit.sv
// Single-outstanding load/store engine for a word-wide RAM without byte enables:
// sub-word stores are done as read-modify-write, loads are lane-extracted and extended.
module dram_access_unit #(
    parameter int XLEN  = 32,
    parameter int LINES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    dram_access_unit_if.slave   bus,
    output logic [XLEN-1:0]     mem_addr,
    output logic                mem_load,
    output logic                mem_store,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [2:0]          dbg_state
);
    localparam int IDX_W = $clog2(LINES);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_RD   = 3'd1;
    localparam logic [2:0] LD_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] RMW_RD  = 3'd4;
    localparam logic [2:0] RMW_MRG = 3'd5;
    localparam logic [2:0] RMW_WR  = 3'd6;
    localparam logic [2:0] RESP    = 3'd7;

    logic [2:0]       state;
    logic [IDX_W+1:0] addr_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]  merge_q;
    logic [XLEN-1:0]  rsp_rdata_q;
    logic             rsp_err_q;

    logic             misaligned;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  ld_fmt;
    logic [XLEN-1:0]  merge_d;

    // Size 11 behaves as a word, so bit 1 alone marks a word access.
    always_comb begin
        misaligned = 1'b0;
        if (bus.req_size == 2'b01 && bus.req_addr[0])
            misaligned = 1'b1;
        if (bus.req_size[1] && bus.req_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_fmt = {{(XLEN-8){ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   ld_fmt = {{(XLEN-16){ld_half[15] & ~uns_q}}, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        merge_d = mem_rdata;
        if (size_q == 2'b00)
            merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr[IDX_W+1:0];
                        size_q      <= bus.req_size;
                        uns_q       <= bus.req_unsigned;
                        wdata_q     <= bus.req_wdata;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= misaligned;
                        if (misaligned)
                            state <= RESP;
                        else if (!bus.req_store)
                            state <= LD_RD;
                        else if (bus.req_size[1])
                            state <= ST_WR;
                        else
                            state <= RMW_RD;
                    end
                end
                LD_RD:   state <= LD_CAP;
                LD_CAP: begin
                    rsp_rdata_q <= ld_fmt;
                    state       <= RESP;
                end
                ST_WR:   state <= RESP;
                RMW_RD:  state <= RMW_MRG;
                RMW_MRG: begin
                    merge_q <= merge_d;
                    state   <= RMW_WR;
                end
                RMW_WR:  state <= RESP;
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so a reset landing mid-operation never writes the RAM.
    assign mem_load      = !rst && (state == LD_RD || state == RMW_RD);
    assign mem_store     = !rst && (state == ST_WR || state == RMW_WR);
    assign mem_wdata     = (state == RMW_WR) ? merge_q : wdata_q;
    assign mem_addr      = {{(XLEN-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_dram_access_unit.sv
// Bench for dram_access_unit: word RAM model, shadow-memory reference, directed and random requests.
module tb_dram_access_unit;
    localparam int XLEN  = 32;
    localparam int LINES = 1024;
    localparam int IDXW  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ram_clear = 1'b1;
    logic [XLEN-1:0] mem_addr;
    logic            mem_load;
    logic            mem_store;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata = '0;
    logic [2:0]      dbg_state;

    dram_access_unit_if #(.XLEN(XLEN)) bus ();

    dram_access_unit #(.XLEN(XLEN), .LINES(LINES)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_load  (mem_load),
        .mem_store (mem_store),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] ram [LINES];
    logic [XLEN-1:0] shadow [LINES];
    int              n_ld = 0;
    int              n_st = 0;
    int              n_both = 0;
    logic [XLEN-1:0] last_ld_addr = '0;
    logic [XLEN-1:0] last_st_addr = '0;
    logic [XLEN-1:0] last_st_wdata = '0;

    // RAM: 1-cycle read latency, read data holds until the next load.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < LINES; i++) ram[i] <= '0;
        end else if (mem_store) begin
            ram[mem_addr[IDXW-1:0]] <= mem_wdata;
        end
        if (mem_load) begin
            mem_rdata    <= ram[mem_addr[IDXW-1:0]];
            n_ld         <= n_ld + 1;
            last_ld_addr <= mem_addr;
        end
        if (mem_store) begin
            n_st          <= n_st + 1;
            last_st_addr  <= mem_addr;
            last_st_wdata <= mem_wdata;
        end
        if (mem_load && mem_store) n_both <= n_both + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [XLEN-1:0] addr);
        return int'((addr >> 2) % LINES);
    endfunction

    function automatic logic model_err(input logic [XLEN-1:0] addr, input logic [1:0] size);
        if (size == 2'd1) return (addr % 2) != 0;
        if (size >= 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] model_load(input logic [XLEN-1:0] addr, input logic [1:0] size,
                                                   input logic uns);
        logic [XLEN-1:0] w;
        logic [XLEN-1:0] v;
        w = shadow[widx(addr)];
        if (size == 2'd0) begin
            v = (w >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [XLEN-1:0] addr, input logic [1:0] size, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] mask;
        logic [XLEN-1:0] sh;
        int i;
        i = widx(addr);
        if (size == 2'd0) begin
            sh   = 8 * (addr % 4);
            mask = 32'hFF << sh;
            shadow[i] = (shadow[i] & ~mask) | ((wd & 32'hFF) << sh);
        end else if (size == 2'd1) begin
            sh   = 16 * ((addr / 2) % 2);
            mask = 32'hFFFF << sh;
            shadow[i] = (shadow[i] & ~mask) | ((wd & 32'hFFFF) << sh);
        end else begin
            shadow[i] = wd;
        end
    endtask

    // One full request/response; hold = cycles of rsp_ready=0 after rsp_valid appears.
    task automatic do_req(input string tag, input logic st, input logic [XLEN-1:0] addr, input logic [1:0] size,
                          input logic uns, input logic [XLEN-1:0] wd, input int hold,
                          output logic [XLEN-1:0] got);
        logic            exp_err;
        logic [XLEN-1:0] exp_rd;
        int              exp_lat, exp_nld, exp_nst, lat, ld0, st0;
        exp_err = model_err(addr, size);
        exp_rd  = (st || exp_err) ? '0 : model_load(addr, size, uns);
        exp_lat = exp_err ? 1 : (!st ? 3 : (size[1] ? 2 : 4));
        exp_nld = (exp_err || (st && size[1])) ? 0 : 1;
        exp_nst = (exp_err || !st) ? 0 : 1;
        if (st && !exp_err) model_store(addr, size, wd);
        ld0 = n_ld;
        st0 = n_st;
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_store    = st;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        got = bus.rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_n_load"}, 32'(n_ld - ld0), 32'(exp_nld));
        check({tag, "_n_store"}, 32'(n_st - st0), 32'(exp_nst));
    endtask

    logic [XLEN-1:0] got;
    int              ld0, st0;

    initial begin
        for (int i = 0; i < LINES; i++) shadow[i] = '0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_store    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_load", 32'(mem_load), 32'd0);
        check("rst_mem_store", 32'(mem_store), 32'd0);
        ram_clear = 1'b0;
        rst       = 1'b0;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        do_req("sw_10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, got);
        check("sw_10_memaddr", last_st_addr, 32'd4);
        do_req("lw_10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, got);
        check("lw_10_memaddr", last_ld_addr, 32'd4);
        check("lw_10_const", got, 32'hDEADBEEF);

        do_req("sw_20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, 0, got);
        do_req("sb_22", 1'b1, 32'h22, 2'b00, 1'b0, 32'h000000AA, 0, got);
        check("sb_22_wdata", last_st_wdata, 32'h11AA3344);
        do_req("lw_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, got);
        check("lw_20_const", got, 32'h11AA3344);

        do_req("sw_0", 1'b1, 32'h0, 2'b10, 1'b0, 32'h8000F0FF, 0, got);
        do_req("lb_0", 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, got);
        check("lb_0_const", got, 32'hFFFFFFFF);
        do_req("lbu_0", 1'b0, 32'h0, 2'b00, 1'b1, 32'h0, 0, got);
        check("lbu_0_const", got, 32'h000000FF);
        do_req("lh_2", 1'b0, 32'h2, 2'b01, 1'b0, 32'h0, 0, got);
        check("lh_2_const", got, 32'hFFFF8000);
        do_req("lhu_2", 1'b0, 32'h2, 2'b01, 1'b1, 32'h0, 0, got);
        check("lhu_2_const", got, 32'h00008000);

        do_req("lw_6_mis", 1'b0, 32'h6, 2'b10, 1'b0, 32'h0, 0, got);
        do_req("lh_3_mis", 1'b0, 32'h3, 2'b01, 1'b0, 32'h0, 0, got);
        do_req("sw_2_mis", 1'b1, 32'h2, 2'b11, 1'b0, 32'h12345678, 0, got);

        do_req("lw_bp", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 5, got);

        do_req("sw_wrap", 1'b1, 32'(4 * LINES + 8), 2'b10, 1'b0, 32'hCAFEF00D, 0, got);
        check("sw_wrap_memaddr", last_st_addr, 32'd2);
        do_req("lw_8", 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 0, got);
        check("lw_8_const", got, 32'hCAFEF00D);

        // Reset while a byte RMW sits in its merge cycle: no write may reach the RAM.
        do_req("sw_55", 1'b1, 32'h0, 2'b10, 1'b0, 32'h55555555, 0, got);
        ld0 = n_ld;
        st0 = n_st;
        bus.req_valid = 1'b1;
        bus.req_store = 1'b1;
        bus.req_addr  = 32'h0;
        bus.req_size  = 2'b00;
        bus.req_wdata = 32'h0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rmwrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rmwrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rmwrst_req_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rmwrst_n_load", 32'(n_ld - ld0), 32'd1);
        check("rmwrst_n_store", 32'(n_st - st0), 32'd0);
        do_req("lw_after_rst", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 0, got);
        check("lw_after_rst_const", got, 32'h55555555);

        for (int n = 0; n < 40; n++) begin
            logic [XLEN-1:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3), got);
        end

        check("never_both_strobes", 32'(n_both), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
